// File: rtl/gpu_bank_pkg.sv
// Shared definitions for the bank arbiter: FSM state encoding, bank address/data
// widths and the default WAIT timeout.
package gpu_bank_pkg;

  localparam int unsigned AddrW          = 8;
  localparam int unsigned DataW          = 8;
  localparam int unsigned CntW           = 4;
  localparam int unsigned DefaultTimeout = 15;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait,
    StDone
  } state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - highest-priority index for this pick
//   valid - at least one request is set
//   index - first set request found scanning upward from ptr, wrapping at NREQ
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IdxW-1:0] ptr,
  output logic            valid,
  output logic [IdxW-1:0] index
);

  logic [IdxW-1:0] cand;

  always_comb begin
    valid = 1'b0;
    index = '0;
    cand  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IdxW'((32'(ptr) + i) % NREQ);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/bank_arbiter.sv
// Round-robin arbiter giving NREQ requesters serialized access to one memory bank.
// Each access runs IDLE -> ISSUE -> WAIT -> DONE; the winner's payload is latched
// in IDLE so request-side changes after that are ignored.
// Ports:
//   clock, reset          - clock and asynchronous active-low reset
//   req, we, addr, wdata  - per-requester request, write enable, address, write data
//   ack, err, rdata       - completion pulse, timeout flag, read data (err/rdata registered)
//   busy                  - FSM is not idle
//   bank_read/bank_write  - registered one-cycle strobes to the bank
//   bank_addr/bank_wdata  - registered bank address and write data
//   bank_rdata            - bank read data
//   bank_finish           - bank completion flag, one cycle after the strobe
module bank_arbiter
  import gpu_bank_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned TIMEOUT = DefaultTimeout
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ-1:0]       we,
  input  logic [AddrW*NREQ-1:0] addr,
  input  logic [DataW*NREQ-1:0] wdata,
  output logic [NREQ-1:0]       ack,
  output logic                  err,
  output logic [DataW-1:0]      rdata,
  output logic                  busy,
  output logic                  bank_read,
  output logic                  bank_write,
  output logic [AddrW-1:0]      bank_addr,
  output logic [DataW-1:0]      bank_wdata,
  input  logic [DataW-1:0]      bank_rdata,
  input  logic                  bank_finish
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e            state_q, state_d;
  logic [IdxW-1:0]   ptr_q, ptr_d;
  logic [IdxW-1:0]   win_q, win_d;
  logic              we_q, we_d;
  logic [AddrW-1:0]  addr_q, addr_d;
  logic [DataW-1:0]  wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [DataW-1:0]  rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              read_q, read_d;
  logic              write_q, write_d;

  logic              pick_valid;
  logic [IdxW-1:0]   pick_idx;

  rr_pick #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .index (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    win_d   = win_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    read_d  = 1'b0;
    write_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          win_d   = pick_idx;
          we_d    = we[pick_idx];
          addr_d  = addr[AddrW*pick_idx +: AddrW];
          wdata_d = wdata[DataW*pick_idx +: DataW];
          // Strobe flops load here so they are high exactly during ISSUE.
          read_d  = !we[pick_idx];
          write_d = we[pick_idx];
          state_d = StIssue;
        end
      end
      StIssue: begin
        cnt_d   = '0;
        state_d = StWait;
      end
      StWait: begin
        cnt_d = cnt_q + 1'b1;
        if (bank_finish) begin
          rdata_d = bank_rdata;
          err_d   = 1'b0;
          state_d = StDone;
        end else if (cnt_q == CntW'(TIMEOUT - 1)) begin
          // This is the TIMEOUT-th WAIT cycle without a finish.
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        ptr_d   = (win_q == IdxW'(NREQ - 1)) ? '0 : win_q + 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      win_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      read_q  <= 1'b0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      win_q   <= win_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      read_q  <= read_d;
      write_q <= write_d;
    end
  end

  always_comb begin
    ack = '0;
    if (state_q == StDone) begin
      ack[win_q] = 1'b1;
    end
  end

  assign busy       = (state_q != StIdle);
  assign err        = err_q;
  assign rdata      = rdata_q;
  assign bank_read  = read_q;
  assign bank_write = write_q;
  assign bank_addr  = addr_q;
  assign bank_wdata = wdata_q;

endmodule

// File: doc/bank_arbiter.md
BANK_ARBITER -- requirements
Module: bank_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 4: number of requesters sharing one bank.
REQ-002 SHALL have parameter TIMEOUT, default 15: maximum WAIT cycles allowed for bank finish.
REQ-003 clock  input  1  system clock; all state updates on posedge.
REQ-004 reset  input  1  reset, asynchronous, active-low.
REQ-005 req  input  NREQ  per-requester access request, held until its ack.
REQ-006 we  input  NREQ  per-requester write enable (1 = write, 0 = read), held with req.
REQ-007 addr  input  8*NREQ  per-requester address; slice i is [8i+7:8i].
REQ-008 wdata  input  8*NREQ  per-requester write data; slice i is [8i+7:8i].
REQ-009 ack  output  NREQ  one-cycle completion pulse to the served requester.
REQ-010 err  output  1  registered; valid with ack; 1 = bank timeout.
REQ-011 rdata  output  8  registered read data; valid with ack on reads.
REQ-012 busy  output  1  1 whenever state is not IDLE.
REQ-013 bank_read  output  1  registered read strobe to the bank.
REQ-014 bank_write  output  1  registered write strobe to the bank.
REQ-015 bank_addr  output  8  registered bank address.
REQ-016 bank_wdata  output  8  registered bank write data.
REQ-017 bank_rdata  input  8  bank data_out.
REQ-018 bank_finish  input  1  bank completion flag, one cycle after the strobe.

Function
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT, DONE.
REQ-020 IDLE, any req set: SHALL pick a winner round-robin, starting at pointer ptr; SHALL latch winner index, we, addr, wdata; SHALL go to ISSUE.
REQ-021 IDLE, no req: SHALL stay IDLE with all strobes 0.
REQ-022 ISSUE: bank_read = !we_latched and bank_write = we_latched SHALL be high for exactly this one cycle; bank_addr/bank_wdata SHALL hold latched values; next state WAIT.
REQ-023 WAIT: strobes SHALL be 0; a 4-bit counter SHALL increment each cycle.
REQ-024 WAIT, bank_finish=1: SHALL capture bank_rdata into rdata, set err=0, go to DONE.
REQ-025 WAIT, counter reaches TIMEOUT with no finish: SHALL set rdata=0, set err=1, go to DONE.
REQ-026 DONE: ack[winner]=1 and all other ack bits 0; ptr SHALL become (winner+1) mod NREQ; next state IDLE.
REQ-027 Nominal latency: req sampled in IDLE at cycle t, strobe in t+1, finish in t+2, ack in t+3; one access per 4 cycles at most.
REQ-028 Requester SHALL drop req the cycle after ack; arbiter SHALL re-sample req only in IDLE.
REQ-029 req changes during ISSUE/WAIT/DONE SHALL be ignored; the latched payload is used.
REQ-030 bank_finish outside WAIT SHALL be ignored.
REQ-031 rdata and err SHALL hold their values until the next DONE.

Reset
REQ-032 reset=0 SHALL immediately force: state IDLE, ptr 0, counter 0, and every output 0.
REQ-033 Reset mid-operation SHALL abort the access with no ack; the bank strobe SHALL drop asynchronously.

Structure
REQ-034 Shared package gpu_bank_pkg SHALL hold the state enum, the address/data width constants (8) and the default TIMEOUT.
REQ-035 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req and ptr; outputs valid and index).

Verification
REQ-036 Single read: req[0]=1, we=0, addr=0x10, bank preloaded 0x5A -> bank_read high one cycle at t+1; ack[0] at t+3 with rdata=0x5A, err=0.
REQ-037 Write then read: req[2] writes 0xC3 to 0xFF, then req[2] reads 0xFF -> bank_write high one cycle with addr 0xFF; the later read returns rdata=0xC3.
REQ-038 Fairness: req=4'b1111 held, each requester re-requesting after its ack -> ack order 0,1,2,3,0, each ack 4 cycles apart.
REQ-039 Timeout: bank_finish tied 0 -> ack at WAIT entry+15 with err=1, rdata=0; next request is served normally.
REQ-040 Reset mid-WAIT: reset=0 in WAIT -> no ack, busy=0, ptr=0; after release, req[1] is served first.
REQ-041 Payload change: addr changed during WAIT -> bank_addr stays at the value latched in IDLE.
